turn_controller: RTL and testbench

- Sequences one tic-tac-toe match around the game_play datapath.
- Accepts move requests over a valid/ready handshake and rejects illegal moves.
- Writes the 18-bit tiles board that game_play evaluates, then waits for game_play's game_over to decide win, draw or next turn.
- Alternates players and forfeits a turn on inactivity.

---
 rtl/turn_controller_pkg.sv | 11 +
 rtl/turn_controller_if.sv | 8 +
 rtl/turn_controller_timer.sv | 21 ++
 rtl/turn_controller.sv | 97 +++++++++
 tb/tb_turn_controller.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/turn_controller_pkg.sv
// ttt_pkg: shared tic-tac-toe tile, winner and controller state encodings
package ttt_pkg;
    localparam logic [3:0] NUM_TILES = 4'd9;
    localparam logic [1:0] TILE_EMPTY = 2'b00;
    localparam logic [1:0] TILE_X = 2'b01;
    localparam logic [1:0] TILE_O = 2'b10;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X = 2'b01;
    localparam logic [1:0] WIN_O = 2'b10;
    typedef enum logic [1:0] {WAIT_MOVE, CHECK, WAIT_RESULT, GAME_END} ctrl_state_t;
endpackage

// File: rtl/turn_controller_if.sv
// turn_controller_if: move request valid/ready handshake
interface turn_controller_if;
    logic move_valid;
    logic [3:0] move_idx;
    logic move_ready;
    modport master(output move_valid, move_idx, input move_ready);
    modport slave(input move_valid, move_idx, output move_ready);
endinterface

// File: rtl/turn_controller_timer.sv
// turn_timer: inactivity counter that pulses expire every TURN_TIMEOUT enabled cycles
module turn_timer #(
    parameter int TURN_TIMEOUT = 0,
    parameter int TMO_W = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    logic [TMO_W-1:0] cnt;
    logic run;
    // a clear on the terminal cycle suppresses the expiry
    assign run = enable && !clear && TURN_TIMEOUT > 0;
    assign expire = run && cnt == TMO_W'(TURN_TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (!reset || clear || expire) cnt <= '0;
        else if (run) cnt <= cnt + TMO_W'(1);
    end
endmodule

// File: rtl/turn_controller.sv
// turn_controller: sequences one tic-tac-toe match around the game_play datapath
module turn_controller
    import ttt_pkg::*;
#(
    parameter int RESULT_LAT = 1,
    parameter int TURN_TIMEOUT = 0,
    parameter int TMO_W = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic new_game,
    turn_controller_if.slave mif,
    input  logic game_over,
    output logic [17:0] tiles,
    output logic player,
    output logic illegal,
    output logic timeout,
    output logic done,
    output logic [1:0] winner,
    output logic [3:0] move_count
);
    ctrl_state_t state;
    logic [3:0] idx;
    logic [2:0] lat;
    logic accept, expire, occupied;
    logic [31:0] tiles_ext;
    assign mif.move_ready = state == WAIT_MOVE;
    assign accept = mif.move_valid && mif.move_ready;
    // padding keeps the tile lookup in range for any 4-bit index
    assign tiles_ext = {14'b0, tiles};
    assign occupied = idx >= NUM_TILES || tiles_ext[{idx, 1'b0} +: 2] != TILE_EMPTY;
    turn_timer #(.TURN_TIMEOUT(TURN_TIMEOUT), .TMO_W(TMO_W)) u_timer (
        .clk(clk),
        .reset(reset),
        .clear(new_game || accept),
        .enable(mif.move_ready),
        .expire(expire)
    );
    always_ff @(posedge clk) begin
        illegal <= 1'b0;
        timeout <= 1'b0;
        if (!reset || new_game) begin
            state <= WAIT_MOVE;
            idx <= '0;
            lat <= '0;
            tiles <= '0;
            player <= 1'b0;
            move_count <= '0;
            winner <= WIN_NONE;
            done <= 1'b0;
        end else begin
            case (state)
                WAIT_MOVE: begin
                    if (accept) begin
                        idx <= mif.move_idx;
                        state <= CHECK;
                    end else if (expire) begin
                        timeout <= 1'b1;
                        player <= ~player;
                    end
                end
                CHECK: begin
                    if (occupied) begin
                        illegal <= 1'b1;
                        state <= WAIT_MOVE;
                    end else begin
                        tiles[{idx, 1'b0} +: 2] <= player ? TILE_O : TILE_X;
                        move_count <= move_count == NUM_TILES ? move_count : move_count + 4'd1;
                        lat <= '0;
                        state <= WAIT_RESULT;
                    end
                end
                WAIT_RESULT: begin
                    if (lat == 3'(RESULT_LAT)) begin
                        if (game_over) begin
                            winner <= player ? WIN_O : WIN_X;
                            done <= 1'b1;
                            state <= GAME_END;
                        end else if (move_count == NUM_TILES) begin
                            winner <= WIN_NONE;
                            done <= 1'b1;
                            state <= GAME_END;
                        end else begin
                            player <= ~player;
                            state <= WAIT_MOVE;
                        end
                    end else begin
                        lat <= lat + 3'd1;
                    end
                end
                GAME_END: begin
                end
                default: state <= WAIT_MOVE;
            endcase
        end
    end
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed and random matches checked against a board-level reference model
module tb_turn_controller;
    logic clk = 1'b0, reset = 1'b0, new_game = 1'b0, game_over = 1'b0, ng_t = 1'b0;
    logic [17:0] tiles, tiles_t;
    logic player, illegal, timeout, done, player_t, illegal_t, timeout_t, done_t;
    logic [1:0] winner, winner_t;
    logic [3:0] move_count, move_count_t;
    int compared = 0, mismatched = 0;
    int board[9];
    int mplayer, mcount, mdone, mwin;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int xwin[5] = '{0, 3, 1, 4, 2};
    int draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    turn_controller_if mif();
    turn_controller_if mif_t();
    turn_controller #(.RESULT_LAT(1), .TURN_TIMEOUT(0), .TMO_W(32)) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .mif(mif), .game_over(game_over),
        .tiles(tiles), .player(player), .illegal(illegal), .timeout(timeout), .done(done),
        .winner(winner), .move_count(move_count)
    );
    turn_controller #(.RESULT_LAT(1), .TURN_TIMEOUT(8), .TMO_W(32)) dut_t (
        .clk(clk), .reset(reset), .new_game(ng_t), .mif(mif_t), .game_over(1'b0),
        .tiles(tiles_t), .player(player_t), .illegal(illegal_t), .timeout(timeout_t), .done(done_t),
        .winner(winner_t), .move_count(move_count_t)
    );
    always #5 clk = ~clk;
    function automatic logic [17:0] packed_board();
        logic [17:0] pb = '0;
        for (int i = 0; i < 9; i++) pb[2*i +: 2] = 2'(board[i]);
        return pb;
    endfunction
    function automatic bit has_line(input int p);
        for (int l = 0; l < 8; l++)
            if (board[lines[l][0]] == p && board[lines[l][1]] == p && board[lines[l][2]] == p) return 1'b1;
        return 1'b0;
    endfunction
    task automatic model_clear();
        for (int i = 0; i < 9; i++) board[i] = 0;
        mplayer = 0;
        mcount = 0;
        mdone = 0;
        mwin = 0;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_tiles"}, tiles, 18'h0);
        chk({tag, "_player"}, player, 0);
        chk({tag, "_ready"}, mif.move_ready, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_winner"}, winner, 0);
        chk({tag, "_count"}, move_count, 0);
        chk({tag, "_illegal"}, illegal, 0);
    endtask
    task automatic pulse_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        model_clear();
        chk_idle("new_game");
    endtask
    task automatic move(input logic [3:0] i);
        bit legal, win;
        chk("ready_pre", mif.move_ready, mdone == 0);
        mif.move_valid = 1'b1;
        mif.move_idx = i;
        step();
        if (mdone != 0) begin
            step();
            mif.move_valid = 1'b0;
            chk("ended_ready", mif.move_ready, 0);
            chk("ended_tiles", tiles, packed_board());
            chk("ended_count", move_count, mcount);
            chk("ended_illegal", illegal, 0);
            return;
        end
        mif.move_valid = 1'b0;
        chk("check_ready", mif.move_ready, 0);
        legal = i < 9 && board[i] == 0;
        step();
        if (!legal) begin
            chk("illegal_pulse", illegal, 1);
            chk("illegal_tiles", tiles, packed_board());
            chk("illegal_player", player, mplayer);
            chk("illegal_ready", mif.move_ready, 1);
            step();
            chk("illegal_once", illegal, 0);
            return;
        end
        board[i] = mplayer + 1;
        mcount++;
        chk("write_tiles", tiles, packed_board());
        chk("write_count", move_count, mcount);
        chk("write_illegal", illegal, 0);
        win = has_line(mplayer + 1);
        // a spurious game_over off the sampling edge must be ignored
        game_over = !win;
        step();
        game_over = win;
        step();
        game_over = 1'b0;
        if (win) begin
            mdone = 1;
            mwin = mplayer + 1;
        end else if (mcount == 9) begin
            mdone = 1;
            mwin = 0;
        end else mplayer ^= 1;
        chk("result_done", done, mdone);
        chk("result_winner", winner, mwin);
        chk("result_player", player, mplayer);
        chk("result_count", move_count, mcount);
        chk("result_ready", mif.move_ready, mdone == 0);
    endtask
    initial begin
        bit exp_to;
        int p;
        mif.move_valid = 1'b0;
        mif.move_idx = '0;
        mif_t.move_valid = 1'b0;
        mif_t.move_idx = '0;
        model_clear();
        repeat (3) step();
        reset = 1'b1;
        chk_idle("reset");
        move(4'd4);
        chk("first_tiles", tiles, 18'h00100);
        chk("first_player", player, 1);
        move(4'd4);
        chk("dup_tiles", tiles, 18'h00100);
        move(4'd12);
        chk("oob_player", player, 1);
        pulse_new_game();
        foreach (xwin[j]) move(4'(xwin[j]));
        chk("xwin_done", done, 1);
        chk("xwin_winner", winner, 2'b01);
        chk("xwin_count", move_count, 5);
        chk("xwin_player", player, 0);
        move(4'd5);
        pulse_new_game();
        foreach (draw[j]) move(4'(draw[j]));
        chk("draw_done", done, 1);
        chk("draw_winner", winner, 2'b00);
        chk("draw_count", move_count, 9);
        move(4'd5);
        pulse_new_game();
        mif.move_valid = 1'b1;
        mif.move_idx = 4'd7;
        step();
        mif.move_valid = 1'b0;
        step();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        chk_idle("ng_in_result");
        step();
        chk_idle("ng_in_result_next");
        move(4'd0);
        mif.move_valid = 1'b1;
        mif.move_idx = 4'd0;
        step();
        mif.move_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        model_clear();
        chk_idle("rst_in_check");
        step();
        chk_idle("rst_in_check_next");
        for (int g = 0; g < 6; g++) begin
            pulse_new_game();
            for (int m = 0; m < 24 && mdone == 0; m++)
                move($urandom_range(0, 3) == 0 ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)));
            if (mdone != 0) move(4'($urandom_range(0, 8)));
        end
        ng_t = 1'b1;
        step();
        ng_t = 1'b0;
        p = 0;
        for (int k = 1; k < 24; k++) begin
            step();
            exp_to = k % 8 == 0;
            if (exp_to) p ^= 1;
            chk("tmo_pulse", timeout_t, exp_to);
            chk("tmo_player", player_t, p);
        end
        mif_t.move_valid = 1'b1;
        mif_t.move_idx = 4'd0;
        step();
        mif_t.move_valid = 1'b0;
        chk("tmo_vs_move_pulse", timeout_t, 0);
        chk("tmo_vs_move_player", player_t, 0);
        chk("tmo_vs_move_ready", mif_t.move_ready, 0);
        step();
        chk("tmo_vs_move_tiles", tiles_t, 18'h00001);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
